// File: rtl/canonical_kmer_stream.sv
// canonical_kmer_stream
// Three-stage, flow-controlled k-mer canonicaliser. Each beat carries one
// 2-bit-encoded k-mer (A=0, C=1, G=2, T=3; base 0 in the top two bits).
// The output is the forward k-mer, its reverse complement, or the smaller of
// the two, selected per beat by in_mode. The strand flag and the palindrome
// flag travel with the beat. Two saturating counters track delivered beats.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid and ready are both high. A producer holds valid and its payload
// stable until that edge. in_ready is a combinational function of the
// pipeline occupancy and out_ready, so a full pipeline that is draining can
// accept a new beat in the same cycle.

module canonical_kmer_stream #(
    parameter int  K      = 31,
    parameter int  CNT_W  = 32,
    localparam int DATA_W = 2 * K
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_strand,
    output logic              out_pal,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_total,
    output logic [CNT_W-1:0]  stat_rc
);

    // Mode encodings. 2'b11 behaves exactly like canonical.
    localparam logic [1:0] MODE_FWD = 2'b01;
    localparam logic [1:0] MODE_RC  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Parameter legality is checked while elaborating.
    if (K < 1 || K > 32) begin : g_bad_k
        $error("canonical_kmer_stream: K=%0d is outside 1..32", K);
    end
    if (CNT_W < 2 || CNT_W > 48) begin : g_bad_cnt_w
        $error("canonical_kmer_stream: CNT_W=%0d is outside 2..48", CNT_W);
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [1:0]        s1_mode;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_fwd;
    logic [DATA_W-1:0] s2_rc;
    logic [1:0]        s2_mode;

    // Stage 3 is the output register set itself (out_valid, out_data, ...).

    // ------------------------------------------------------------------
    // Ready chain: a stage may load when it is empty or when the stage
    // after it is loading this same edge. Bubbles therefore collapse.
    // ------------------------------------------------------------------
    logic s1_accept;
    logic s2_accept;
    logic s3_accept;
    logic deliver;

    // Combinational ready chain from the output back to in_ready.
    always_comb begin
        s3_accept = !out_valid || out_ready;
        s2_accept = !s2_valid  || s3_accept;
        s1_accept = !s1_valid  || s2_accept;
        in_ready  = s1_accept;
        deliver   = out_valid && out_ready;
    end

    // ------------------------------------------------------------------
    // Reverse complement of the stage-1 k-mer. Complementing a base is a
    // bitwise invert of its two bits (A<->T, C<->G), so rc is the forward
    // word with its 2-bit groups reversed and inverted. Only DATA_W bits
    // exist, so no masking or realignment is needed afterwards.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] s1_rc;

    // Reverse the base order and complement every base.
    always_comb begin
        s1_rc = '0;
        for (int i = 0; i < K; i++) begin
            s1_rc[DATA_W-1-2*i -: 2] = ~s1_data[2*i +: 2];
        end
    end

    // ------------------------------------------------------------------
    // Selection between forward and reverse complement, evaluated on the
    // stage-2 registers and captured by stage 3. A tie picks forward with
    // strand 0, which is what a palindrome produces in canonical mode.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sel_data;
    logic              sel_strand;
    logic              sel_pal;

    // Per-beat mode selection and flag generation.
    always_comb begin
        sel_data   = s2_fwd;
        sel_strand = 1'b0;
        sel_pal    = (s2_fwd == s2_rc);
        case (s2_mode)
            MODE_FWD: begin
                sel_data   = s2_fwd;
                sel_strand = 1'b0;
            end
            MODE_RC: begin
                sel_data   = s2_rc;
                sel_strand = 1'b1;
            end
            default: begin
                if (s2_rc < s2_fwd) begin
                    sel_data   = s2_rc;
                    sel_strand = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the incoming k-mer and its mode. Payload is only
    // loaded for a real beat, so in_data is ignored while in_valid is low.
    // ------------------------------------------------------------------
    // Stage 1 register with valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= '0;
        end else if (s1_accept) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: hold forward and reverse complement side by side so the
    // compare in front of stage 3 works from registers.
    // ------------------------------------------------------------------
    // Stage 2 register with valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_fwd   <= '0;
            s2_rc    <= '0;
            s2_mode  <= '0;
        end else if (s2_accept) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_fwd  <= s1_data;
                s2_rc   <= s1_rc;
                s2_mode <= s1_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: registered outputs. While stalled (out_valid & !out_ready)
    // s3_accept is low, so the payload cannot change.
    // ------------------------------------------------------------------
    // Stage 3 output register with valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_strand <= 1'b0;
            out_pal    <= 1'b0;
        end else if (s3_accept) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data   <= sel_data;
                out_strand <= sel_strand;
                out_pal    <= sel_pal;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics. A clear wins over a delivery on the same edge, so the
    // counters read zero afterwards. Both counters stick at all-ones.
    // ------------------------------------------------------------------
    // Saturating delivery counters with synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_rc    <= '0;
        end else if (stat_clr) begin
            stat_total <= '0;
            stat_rc    <= '0;
        end else if (deliver) begin
            if (stat_total != CNT_MAX) begin
                stat_total <= stat_total + CNT_ONE;
            end
            if (out_strand && (stat_rc != CNT_MAX)) begin
                stat_rc <= stat_rc + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_canonical_kmer_stream.sv
// Testbench for canonical_kmer_stream.
// Two instances: a K=4 / CNT_W=4 block for directed, backpressure, counter
// saturation and reset scenarios, and a default K=31 block for wide data.
// Expected results come from a base-by-base model of the canonical rule and
// are queued at stimulus time; monitors pop and compare on each delivery.

module tb_canonical_kmer_stream;

  // ----------------------------------------------------------------
  // Clock and reset
  // ----------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ----------------------------------------------------------------
  // DUT A: K=4, CNT_W=4
  // ----------------------------------------------------------------
  logic [7:0] a_in_data = '0;
  logic [1:0] a_in_mode = '0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_out_data;
  logic       a_out_strand;
  logic       a_out_pal;
  logic       a_out_valid;
  logic       a_out_ready = 1'b1;
  logic       a_stat_clr = 1'b0;
  logic [3:0] a_stat_total;
  logic [3:0] a_stat_rc;

  canonical_kmer_stream #(.K(4), .CNT_W(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (a_in_data),
    .in_mode    (a_in_mode),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .out_data   (a_out_data),
    .out_strand (a_out_strand),
    .out_pal    (a_out_pal),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .stat_clr   (a_stat_clr),
    .stat_total (a_stat_total),
    .stat_rc    (a_stat_rc)
  );

  // ----------------------------------------------------------------
  // DUT B: default K=31, CNT_W=32
  // ----------------------------------------------------------------
  logic [61:0] b_in_data = '0;
  logic [1:0]  b_in_mode = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [61:0] b_out_data;
  logic        b_out_strand;
  logic        b_out_pal;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_stat_clr = 1'b0;
  logic [31:0] b_stat_total;
  logic [31:0] b_stat_rc;

  canonical_kmer_stream dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (b_in_data),
    .in_mode    (b_in_mode),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .out_data   (b_out_data),
    .out_strand (b_out_strand),
    .out_pal    (b_out_pal),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .stat_clr   (b_stat_clr),
    .stat_total (b_stat_total),
    .stat_rc    (b_stat_rc)
  );

  // ----------------------------------------------------------------
  // Bookkeeping
  // ----------------------------------------------------------------
  int n_tests = 0;
  int n_fails = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        strand;
    logic        pal;
  } res_t;
  localparam int RES_W = $bits(res_t);

  logic [RES_W-1:0] exp_a_q[$];
  logic [RES_W-1:0] exp_b_q[$];

  int a_acc = 0;
  logic rand_rdy_a = 1'b0;
  logic rand_rdy_b = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------------------
  // Reference model: works base by base from the encoding rules.
  // ----------------------------------------------------------------
  function automatic logic [63:0] rc_of(input logic [63:0] d, input int k);
    logic [63:0] r;
    int b;
    r = '0;
    for (int i = 0; i < k; i++) begin
      // base (k-1-i) of the forward word sits in the i-th pair from the LSB
      b = int'((d >> (2 * i)) & 64'd3);
      // it becomes base i of the result, complemented
      r = r | (64'(3 - b) << (2 * (k - 1 - i)));
    end
    return r;
  endfunction

  function automatic res_t ref_model(input logic [63:0] d, input logic [1:0] m, input int k);
    res_t r;
    logic [63:0] rc;
    rc = rc_of(d, k);
    r.pal = (d == rc);
    if (m == 2'd1) begin
      r.data = d;   r.strand = 1'b0;
    end else if (m == 2'd2) begin
      r.data = rc;  r.strand = 1'b1;
    end else if (rc < d) begin
      r.data = rc;  r.strand = 1'b1;
    end else begin
      r.data = d;   r.strand = 1'b0;
    end
    return r;
  endfunction

  function automatic res_t mk(input logic [63:0] d, input logic s, input logic p);
    res_t r;
    r.data = d; r.strand = s; r.pal = p;
    return r;
  endfunction

  // ----------------------------------------------------------------
  // Driver tasks. Called at posedge+1; return at posedge+1 after the
  // accepting edge, so consecutive calls give back-to-back beats.
  // ----------------------------------------------------------------
  task automatic send_a(input logic [7:0] d, input logic [1:0] m, input res_t e);
    int waited;
    waited = 0;
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
    while (1) begin
      @(negedge clk);
      if (a_in_ready) break;
      waited++;
      if (waited > 300) begin
        check("a_send_timeout", 64'(waited), 64'd0);
        a_in_valid = 1'b0;
        return;
      end
    end
    exp_a_q.push_back(e);
    a_acc++;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data = 8'($urandom);
    a_in_mode = 2'($urandom);
  endtask

  task automatic send_a_rand(input logic [1:0] m);
    logic [7:0] d;
    d = 8'($urandom);
    send_a(d, m, ref_model({56'b0, d}, m, 4));
  endtask

  task automatic send_b(input logic [61:0] d, input logic [1:0] m, input res_t e);
    int waited;
    waited = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_mode = m;
    while (1) begin
      @(negedge clk);
      if (b_in_ready) break;
      waited++;
      if (waited > 300) begin
        check("b_send_timeout", 64'(waited), 64'd0);
        b_in_valid = 1'b0;
        return;
      end
    end
    exp_b_q.push_back(e);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_data = {30'($urandom), $urandom};
  endtask

  task automatic drain_a();
    int w;
    w = 0;
    while (exp_a_q.size() != 0 && w < 500) begin @(negedge clk); w++; end
    check("a_drain", 64'(exp_a_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    int w;
    w = 0;
    while (exp_b_q.size() != 0 && w < 500) begin @(negedge clk); w++; end
    check("b_drain", 64'(exp_b_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Random downstream readiness during the random phases.
  always @(posedge clk) begin
    #1;
    if (rand_rdy_a) a_out_ready = ($urandom_range(0, 3) != 0);
    if (rand_rdy_b) b_out_ready = ($urandom_range(0, 2) != 0);
  end

  // ----------------------------------------------------------------
  // Scoreboard monitor for DUT A (data, hold stability, counters)
  // ----------------------------------------------------------------
  int          a_tot_m = 0;
  int          a_rc_m = 0;
  logic        a_stall = 1'b0;
  logic [9:0]  a_hold_v = '0;
  res_t        a_e;
  logic        a_del;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_tot_m = 0; a_rc_m = 0; a_stall = 1'b0;
    end else begin
      check("a_stat_total", 64'(a_stat_total), 64'(a_tot_m));
      check("a_stat_rc", 64'(a_stat_rc), 64'(a_rc_m));
      a_del = 1'b0;
      if (a_out_valid && a_out_ready) begin
        if (exp_a_q.size() == 0) begin
          check("a_unexpected_beat", {56'b0, a_out_data}, 64'hDEAD);
        end else begin
          a_e = res_t'(exp_a_q.pop_front());
          a_del = 1'b1;
          check("a_out_data", {56'b0, a_out_data}, a_e.data);
          check("a_out_strand", 64'(a_out_strand), 64'(a_e.strand));
          check("a_out_pal", 64'(a_out_pal), 64'(a_e.pal));
        end
      end
      if (a_out_valid && !a_out_ready) begin
        if (a_stall) check("a_hold_stable", 64'({a_out_data, a_out_strand, a_out_pal}), 64'(a_hold_v));
        a_hold_v = {a_out_data, a_out_strand, a_out_pal};
        a_stall = 1'b1;
      end else begin
        a_stall = 1'b0;
      end
      // counter values expected after the coming edge
      if (a_stat_clr) begin
        a_tot_m = 0; a_rc_m = 0;
      end else if (a_del) begin
        if (a_tot_m < 15) a_tot_m++;
        if (a_e.strand && a_rc_m < 15) a_rc_m++;
      end
    end
  end

  // ----------------------------------------------------------------
  // Scoreboard monitor for DUT B
  // ----------------------------------------------------------------
  int   b_deliv = 0;
  int   b_rcs = 0;
  res_t b_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_deliv = 0; b_rcs = 0;
    end else if (b_out_valid && b_out_ready) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_beat", {2'b0, b_out_data}, 64'hDEAD);
      end else begin
        b_e = res_t'(exp_b_q.pop_front());
        check("b_out_data", {2'b0, b_out_data}, b_e.data);
        check("b_out_strand", 64'(b_out_strand), 64'(b_e.strand));
        check("b_out_pal", 64'(b_out_pal), 64'(b_e.pal));
        b_deliv++;
        if (b_e.strand) b_rcs++;
      end
    end
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------------
  // Main sequence
  // ----------------------------------------------------------------
  logic seen;
  int   base_acc;

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_data", 64'(a_out_data), 64'd0);
    check("rst_out_flags", 64'({a_out_strand, a_out_pal}), 64'd0);
    check("rst_stats", 64'({a_stat_total, a_stat_rc}), 64'd0);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk); #1;

    // 1: ACGT palindrome and first-beat latency
    send_a(8'h1B, 2'd0, mk(64'h1B, 1'b0, 1'b1));
    @(negedge clk); check("lat_edge_n", 64'(a_out_valid), 64'd0);
    @(negedge clk); check("lat_edge_n1", 64'(a_out_valid), 64'd0);
    @(negedge clk); check("lat_edge_n2", 64'(a_out_valid), 64'd1);
    @(posedge clk); #1;

    // 2: directed modes
    send_a(8'hFF, 2'd0, mk(64'h00, 1'b1, 1'b0));
    send_a(8'h01, 2'd0, mk(64'h01, 1'b0, 1'b0));
    send_a(8'hFF, 2'd1, mk(64'hFF, 1'b0, 1'b0));
    send_a(8'hFF, 2'd2, mk(64'h00, 1'b1, 1'b0));
    send_a(8'hFF, 2'd3, mk(64'h00, 1'b1, 1'b0));
    send_a(8'h1B, 2'd1, mk(64'h1B, 1'b0, 1'b1));
    send_a(8'h1B, 2'd2, mk(64'h1B, 1'b1, 1'b1));
    drain_a();

    // 3: K=31 back-to-back beats on consecutive cycles
    send_b(62'h3FFF_FFFF_FFFF_FFFF, 2'd0, mk(64'h0, 1'b1, 1'b0));
    send_b(62'h0, 2'd0, mk(64'h0, 1'b0, 1'b0));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (b_out_valid) seen = 1'b1;
    end
    check("b_first_valid", 64'(seen), 64'd1);
    check("b_first_strand", 64'(b_out_strand), 64'd1);
    @(negedge clk);
    check("b_second_valid", 64'(b_out_valid), 64'd1);
    check("b_second_flags", 64'({b_out_strand, b_out_pal}), 64'd0);
    @(posedge clk); #1;
    drain_b();

    // 4: backpressure, capacity three, ordered gap-free release
    a_out_ready = 1'b0;
    base_acc = a_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) send_a_rand(2'($urandom_range(0, 3)));
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_accepted", 64'(a_acc - base_acc), 64'd3);
        check("bp_in_ready", 64'(a_in_ready), 64'd0);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          check("bp_no_gap", 64'(a_out_valid), 64'd1);
        end
      end
    join
    drain_a();

    // Random traffic with random gaps and random backpressure
    rand_rdy_a = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send_a_rand(2'($urandom_range(0, 3)));
    end
    rand_rdy_a = 1'b0;
    a_out_ready = 1'b1;
    drain_a();

    rand_rdy_b = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [61:0] d;
      logic [1:0]  m;
      d = {30'($urandom), $urandom};
      m = 2'($urandom_range(0, 3));
      send_b(d, m, ref_model({2'b0, d}, m, 31));
    end
    rand_rdy_b = 1'b0;
    b_out_ready = 1'b1;
    drain_b();
    @(negedge clk);
    check("b_stat_total", 64'(b_stat_total), 64'(b_deliv));
    check("b_stat_rc", 64'(b_stat_rc), 64'(b_rcs));
    @(posedge clk); #1;

    // 5: saturation and clear racing a delivery
    a_stat_clr = 1'b1;
    @(posedge clk); #1;
    a_stat_clr = 1'b0;
    @(negedge clk);
    check("clr_total", 64'(a_stat_total), 64'd0);
    check("clr_rc", 64'(a_stat_rc), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) send_a(8'hFF, 2'd0, mk(64'h00, 1'b1, 1'b0));
    drain_a();
    @(negedge clk);
    check("sat_total", 64'(a_stat_total), 64'd15);
    check("sat_rc", 64'(a_stat_rc), 64'd15);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    send_a(8'hFF, 2'd0, mk(64'h00, 1'b1, 1'b0));
    repeat (3) @(posedge clk);
    #1;
    a_stat_clr = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_stat_clr = 1'b0;
    @(negedge clk);
    check("clr_vs_deliver_total", 64'(a_stat_total), 64'd0);
    check("clr_vs_deliver_rc", 64'(a_stat_rc), 64'd0);
    @(posedge clk); #1;
    drain_a();

    // 6: reset with beats in flight
    send_a_rand(2'd0);
    send_a_rand(2'd1);
    drain_a();
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_a_rand(2'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_a_q.delete();
    check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_out_data", 64'(a_out_data), 64'd0);
    check("mid_rst_stats", 64'({a_stat_total, a_stat_rc}), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("post_rst_no_stale", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // Post-reset traffic still flows
    for (int i = 0; i < 5; i++) send_a_rand(2'($urandom_range(0, 3)));
    drain_a();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
